fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port BranchTaken_i  input  1  the EX-stage resolved branch outcome, already gated by Branch.
REQ-005 SHALL have port Jump_i  input  1  the EX-stage JAL/JALR indication.
REQ-006 SHALL have port BranchTarget_i  input  32  the EX-stage computed redirect target.
REQ-007 SHALL have port Stall_i  input  1  the hazard-unit hold request for IF and IF/ID.
REQ-008 SHALL have port imem_req_o  output  1  the instruction-memory request.
REQ-009 SHALL have port imem_addr_o  output  32  the instruction-memory address.
REQ-010 SHALL have port imem_ready_i  input  1  the memory accept signal; imem_rdata_i is valid in the same cycle.
REQ-011 SHALL have port imem_rdata_i  input  32  the fetched instruction word.
REQ-012 SHALL have port pc_o  output  32  the IF/ID PC.
REQ-013 SHALL have port instr_o  output  32  the IF/ID instruction.
REQ-014 SHALL have port valid_o  output  1  the IF/ID valid bit.
REQ-015 SHALL have port Flush_o  output  1  the kill signal for the instruction in ID (ID/EX bubble).
REQ-016 SHALL have port MisalignedTarget_o  output  1  the misaligned-target fault, as a one-cycle pulse.

Function
REQ-017 SHALL implement the FSM states BOOT, RUN and HALT.
  - BOOT->RUN unconditionally after one cycle.
  - RUN->HALT on a misaligned redirect.
  - HALT exits only on reset.
REQ-018 SHALL define redirect as (BranchTaken_i | Jump_i) in RUN. Both asserted together is a single redirect to BranchTarget_i.
REQ-019 SHALL classify a redirect as misaligned when BranchTarget_i[1:0] != 2'b00, and as a valid redirect otherwise.
REQ-020 SHALL drive imem_addr_o = pc_q combinationally at all times.
REQ-021 SHALL drive imem_req_o = (state==RUN) & ~Stall_i & ~redirect.
  - imem_req_o is 0 in BOOT and HALT.
REQ-022 SHALL perform an accepted fetch when imem_req_o & imem_ready_i. On that edge:
  - pc_q <= pc_q + 4, modulo 2^32 (wrap from 32'hFFFF_FFFC to 0).
  - pc_o <= pc_q.
  - instr_o <= imem_rdata_i.
  - valid_o <= 1.
REQ-023 SHALL handle RUN with imem_req_o=1 and imem_ready_i=0 as follows: hold pc_q, set valid_o <= 0, hold pc_o and instr_o.
REQ-024 SHALL, on Stall_i=1 with no redirect, hold pc_q, pc_o, instr_o and valid_o unchanged.
REQ-025 SHALL, on a valid redirect (regardless of Stall_i or imem_ready_i):
  - set pc_q <= BranchTarget_i and valid_o <= 0;
  - assert Flush_o=1 combinationally in the same cycle.
REQ-026 SHALL, on a misaligned redirect:
  - assert Flush_o=1 combinationally;
  - set valid_o <= 0;
  - hold pc_q;
  - set MisalignedTarget_o <= 1 for exactly one cycle;
  - move the FSM to HALT.
REQ-027 SHALL ignore BranchTaken_i and Jump_i in BOOT and HALT, with Flush_o=0 in both states.
REQ-028 SHALL keep Flush_o=0 whenever no redirect is active.
REQ-029 SHALL have a redirect-to-first-fetch latency of one cycle: the target is presented on imem_addr_o in the cycle after the redirect.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force:
  - state=BOOT and pc_q=RESET_PC;
  - pc_o=0, instr_o=32'h0000_0013 (NOP);
  - valid_o=0, MisalignedTarget_o=0.
REQ-031 SHALL hold imem_req_o=0 and Flush_o=0 while in reset and during BOOT.
REQ-032 SHALL, on reset asserted mid-operation (including in HALT), abandon any fetch and restart from RESET_PC.

Verification
REQ-033 Sequential fetch: reset release, imem_ready_i=1 -> req=0 in BOOT; then addresses 0x0, 0x4, 0x8 on consecutive cycles; pc_o/instr_o/valid_o=1 follow one cycle later.
REQ-034 Stall and wait: Stall_i=1 for 2 cycles at pc_q=0x10 -> req=0 and IF/ID frozen. Then imem_ready_i=0 for 1 cycle -> valid_o=0 and pc_q stays 0x10.
REQ-035 Branch redirect: BranchTaken_i=1, target=0x100, with Stall_i=1 and imem_ready_i=0 -> Flush_o=1 the same cycle, valid_o=0 and imem_addr_o=0x100 next cycle.
REQ-036 Misaligned jump: Jump_i=1, target=0x102 -> Flush_o=1, one-cycle MisalignedTarget_o pulse, FSM in HALT with req=0. A later BranchTaken_i=1 produces no Flush_o.
REQ-037 Wrap and reset: pc_q=0xFFFF_FFFC accepted -> pc_q=0x0. Asserting rst_n=0 mid-stream -> immediate reset values, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC unit: drives the instruction-memory request and loads the IF/ID register.
// Latency: IF/ID loads on the edge that accepts a fetch; a redirect target appears on imem_addr_o the next cycle.
// Backpressure: Stall_i freezes PC and IF/ID; imem_ready_i=0 holds the PC and inserts a bubble (valid_o=0).
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   BranchTaken_i, Jump_i      - EX-stage redirect requests (used only in RUN)
//   BranchTarget_i             - redirect target address
//   Stall_i                    - hazard-unit hold for IF and IF/ID
//   imem_req_o, imem_addr_o    - instruction-memory request and address (address is always pc_q)
//   imem_ready_i, imem_rdata_i - memory accept and same-cycle instruction data
//   pc_o, instr_o, valid_o     - IF/ID register contents
//   Flush_o                    - kill for the instruction in ID, asserted with any redirect
//   MisalignedTarget_o         - one-cycle pulse on a misaligned redirect
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        BranchTaken_i,
  input  logic        Jump_i,
  input  logic [31:0] BranchTarget_i,
  input  logic        Stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        Flush_o,
  output logic        MisalignedTarget_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic        misal_q, misal_d;

  logic redirect;
  logic misaligned;
  logic req;

  // Redirect requests only count while running; BOOT and HALT ignore them.
  assign redirect   = (state_q == RUN) & (BranchTaken_i | Jump_i);
  assign misaligned = redirect & (BranchTarget_i[1:0] != 2'b00);
  // A redirect suppresses the request: the current PC is on the wrong path.
  assign req        = (state_q == RUN) & ~Stall_i & ~redirect;

  assign imem_req_o         = req;
  assign imem_addr_o        = pc_q;
  assign Flush_o            = redirect;
  assign pc_o               = id_pc_q;
  assign instr_o            = id_instr_q;
  assign valid_o            = id_valid_q;
  assign MisalignedTarget_o = misal_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    misal_d    = 1'b0;

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (misaligned) begin
          // Keep the PC so the faulting context stays visible; stop fetching.
          id_valid_d = 1'b0;
          misal_d    = 1'b1;
          state_d    = HALT;
        end else if (redirect) begin
          // Redirect wins over stall and memory backpressure.
          pc_d       = BranchTarget_i;
          id_valid_d = 1'b0;
        end else if (Stall_i) begin
          // Everything holds.
        end else if (imem_ready_i) begin
          pc_d       = pc_q + 32'd4;
          id_pc_d    = pc_q;
          id_instr_d = imem_rdata_i;
          id_valid_d = 1'b1;
        end else begin
          // Request outstanding but not accepted: bubble into ID, keep old PC/instr.
          id_valid_d = 1'b0;
        end
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'h0000_0000;
      id_instr_q <= NOP;
      id_valid_q <= 1'b0;
      misal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      misal_q    <= misal_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam logic [31:0] KEY = 32'h1300_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bt = 1'b0;
  logic        jmp = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        stall = 1'b0;
  logic        rdy = 1'b1;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        flush;
  logic        misal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory returns an address-derived word so instr_o also proves which address was fetched.
  assign rdata = addr ^ KEY;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .BranchTaken_i(bt), .Jump_i(jmp), .BranchTarget_i(tgt), .Stall_i(stall),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ready_i(rdy), .imem_rdata_i(rdata),
    .pc_o(pc_o), .instr_o(instr_o), .valid_o(valid_o),
    .Flush_o(flush), .MisalignedTarget_o(misal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_booting = 1'b1;
  logic        m_halted  = 1'b0;
  logic [31:0] m_pc      = 32'h0;
  logic [31:0] m_id_pc   = 32'h0;
  logic [31:0] m_id_ins  = 32'h13;
  logic        m_id_vld  = 1'b0;
  logic        m_mis     = 1'b0;

  function automatic logic m_redirect();
    return !m_booting && !m_halted && (bt || jmp);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_booting <= 1'b1; m_halted <= 1'b0; m_pc <= 32'h0;
      m_id_pc <= 32'h0; m_id_ins <= 32'h13; m_id_vld <= 1'b0; m_mis <= 1'b0;
    end else begin
      m_mis <= 1'b0;
      if (m_booting) m_booting <= 1'b0;
      else if (m_halted) begin
      end else if (bt || jmp) begin
        m_id_vld <= 1'b0;
        if (tgt % 4 != 0) begin m_mis <= 1'b1; m_halted <= 1'b1; end
        else m_pc <= tgt;
      end else if (stall) begin
      end else if (rdy) begin
        m_id_pc  <= m_pc;
        m_id_ins <= m_pc ^ KEY;
        m_id_vld <= 1'b1;
        m_pc     <= m_pc + 4;
      end else m_id_vld <= 1'b0;
    end
  end

  // Compare every cycle on the falling edge, when inputs and state are stable.
  always @(negedge clk) begin
    chk("imem_req", {31'b0, req}, {31'b0, !m_booting && !m_halted && !stall && !m_redirect()});
    chk("imem_addr", addr, m_pc);
    chk("flush", {31'b0, flush}, {31'b0, m_redirect()});
    chk("pc_o", pc_o, m_id_pc);
    chk("instr_o", instr_o, m_id_ins);
    chk("valid_o", {31'b0, valid_o}, {31'b0, m_id_vld});
    chk("misaligned", {31'b0, misal}, {31'b0, m_mis});
  end

  // Hold the given inputs for one full cycle; returns at posedge+2.
  task automatic apply(input logic b, input logic j, input logic [31:0] t,
                       input logic s, input logic r);
    bt = b; jmp = j; tgt = t; stall = s; rdy = r;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 32'h0, 0, 1);
  endtask

  initial begin
    // Reset values.
    @(posedge clk); #2;
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_instr", instr_o, 32'h13);
    chk("rst_req", {31'b0, req}, 32'h0);
    rst_n = 1'b1;
    // BOOT cycle: no request.
    chk("boot_req", {31'b0, req}, 32'h0);
    idle(1);
    chk("run_addr0", addr, 32'h0);
    chk("run_req", {31'b0, req}, 32'h1);
    idle(1);
    chk("seq_addr4", addr, 32'h4);
    chk("seq_pc_o", pc_o, 32'h0);
    chk("seq_instr", instr_o, 32'h0 ^ KEY);
    chk("seq_valid", {31'b0, valid_o}, 32'h1);
    idle(3);
    chk("at_10", addr, 32'h10);
    // Stall two cycles.
    apply(0, 0, 32'h0, 1, 1);
    apply(0, 0, 32'h0, 1, 1);
    chk("stall_pc_o", pc_o, 32'hC);
    chk("stall_addr", addr, 32'h10);
    // Memory not ready one cycle.
    apply(0, 0, 32'h0, 0, 0);
    chk("wait_valid", {31'b0, valid_o}, 32'h0);
    chk("wait_addr", addr, 32'h10);
    chk("wait_pc_o", pc_o, 32'hC);
    // Branch while stalled and memory not ready.
    bt = 1; tgt = 32'h100; stall = 1; rdy = 0; #1;
    chk("br_flush", {31'b0, flush}, 32'h1);
    chk("br_req", {31'b0, req}, 32'h0);
    @(posedge clk); #2;
    chk("br_addr", addr, 32'h100);
    chk("br_valid", {31'b0, valid_o}, 32'h0);
    idle(1);
    // Branch and jump together: one redirect.
    apply(1, 1, 32'h200, 0, 1);
    chk("both_addr", addr, 32'h200);
    idle(2);
    // Misaligned jump.
    apply(0, 1, 32'h102, 0, 1);
    chk("mis_pulse", {31'b0, misal}, 32'h1);
    chk("mis_hold_pc", addr, 32'h208);
    apply(1, 0, 32'h300, 0, 1);
    chk("mis_one_cycle", {31'b0, misal}, 32'h0);
    chk("halt_req", {31'b0, req}, 32'h0);
    bt = 1; #1;
    chk("halt_no_flush", {31'b0, flush}, 32'h0);
    bt = 0;
    idle(1);
    // Asynchronous reset while halted, away from any edge.
    #1 rst_n = 1'b0;
    #1;
    chk("arst_addr", addr, 32'h0);
    chk("arst_valid", {31'b0, valid_o}, 32'h0);
    chk("arst_instr", instr_o, 32'h13);
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle(2);
    chk("restart_addr", addr, 32'h4);
    // Wrap at the top of the address space.
    apply(1, 0, 32'hFFFF_FFFC, 0, 1);
    idle(1);
    chk("wrap_addr", addr, 32'h0);
    chk("wrap_pc_o", pc_o, 32'hFFFF_FFFC);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
